alarm_mode_ctrl: RTL
====================

Name: alarm_mode_ctrl

Overview:
Central user-interface sequencer for the alarm clock. It consumes single-cycle pulses from five push-button detector chains (centre/up/down/left/right) and the 1 Hz tick. It sequences normal/adjust/ringing modes, issues inc/dec pulses to the external time counter, and owns the alarm-time and alarm-enable registers. It sits between the push-button detectors and the timekeeping/display datapath.

Parameters:
RING_SECS, 30, number of tick_1hz pulses the alarm rings before auto-stop (1..255)
HR_MAX, 23, maximum alarm hour value
MIN_MAX, 59, maximum alarm minute value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_c  in  1  centre button pulse, one cycle wide
btn_u  in  1  up button pulse
btn_d  in  1  down button pulse
btn_l  in  1  left button pulse
btn_r  in  1  right button pulse
tick_1hz  in  1  one-cycle pulse per second
alarm_match  in  1  high while current time equals alarm time (level)
adjust_mode  out  1  high in any ADJ_* state
field_sel  out  2  0=time hr, 1=time min, 2=alarm hr, 3=alarm min; 0 outside adjust
field_blink  out  1  toggles on tick_1hz while adjusting; 0 otherwise
time_inc_hr, time_dec_hr, time_inc_min, time_dec_min  out  1 each  one-cycle pulses to time counter
alarm_hr  out  5  alarm hour, 0..HR_MAX
alarm_min  out  6  alarm minute, 0..MIN_MAX
alarm_en  out  1  alarm armed
ringing  out  1  high in RINGING state

Behaviour:
- Reset (async, immediate): state CLOCK, all pulses 0, alarm_hr=0, alarm_min=0, alarm_en=0, field_blink=0, ring counter 0, match-edge register 0. Reset mid-ring or mid-adjust returns to CLOCK with the same values.
- All outputs registered. Effect of a button pulse appears on the clock edge after the pulse cycle: 1-cycle latency. Pulses high for exactly one cycle per button pulse.
- States: CLOCK, ADJ_T_HR, ADJ_T_MIN, ADJ_A_HR, ADJ_A_MIN, RINGING.
- Button priority per cycle: btn_c > (btn_l/btn_r) > (btn_u/btn_d). The highest-priority asserted group is acted on; lower ones are dropped. l+r together: both ignored, and u/d in that cycle are also dropped. u+d together: both ignored.
- CLOCK:
  - btn_c -> ADJ_T_HR.
  - btn_u -> alarm_en=1.
  - btn_d -> alarm_en=0.
  - l/r ignored.
  - Rising edge of alarm_match (registered previous value) with alarm_en=1 -> RINGING, ring counter cleared.
- ADJ_* states:
  - btn_c -> CLOCK.
  - btn_r -> next field, cyclic T_HR->T_MIN->A_HR->A_MIN->T_HR.
  - btn_l -> previous field, cyclic.
  - btn_u/btn_d: in T_HR/T_MIN, pulse time_inc_*/time_dec_*; in A_HR/A_MIN, modify the alarm register with wrap. HR_MAX+1 -> 0; 0-1 -> HR_MAX; same for minutes with MIN_MAX.
  - alarm_match edges are ignored; no ringing while adjusting. The edge register still tracks, so returning to CLOCK while alarm_match is already high does not ring.
- field_blink: in ADJ_*, toggles on each tick_1hz; forced 0 on entry to/exit from adjust and on a field change.
- RINGING:
  - Any button pulse -> CLOCK; the button's normal action is not performed and alarm_en is unchanged.
  - Each tick_1hz increments the ring counter. When it reaches RING_SECS -> CLOCK.
  - If a button and the final tick land in the same cycle -> CLOCK (single exit).
- Time-counter pulses are never issued outside T_HR/T_MIN.

Test Plan:
- Reset, then btn_u pulse in CLOCK -> alarm_en=1 one cycle later; btn_d -> alarm_en=0; no time_* pulses at any point.
- btn_c, btn_r, btn_r, then btn_u 3x -> field_sel walks 0,1,2; alarm_hr 0->3. Next btn_d 4x -> alarm_hr 3->23 (wrap at 0).
- In ADJ_T_MIN, btn_u and btn_d in the same cycle -> no pulse. btn_c with btn_u in the same cycle -> CLOCK, no time_inc_min.
- alarm_en=1, alarm_match rises in CLOCK -> ringing=1 next cycle. With RING_SECS=3, three tick_1hz -> ringing=0 after the third.
- Ringing, btn_l pulse -> ringing=0, state CLOCK, alarm_en still 1. alarm_match still high does not retrigger.
- Assert rst while in ADJ_A_MIN with alarm_min=45 -> outputs immediately at reset values (alarm_min=0, adjust_mode=0) without a clock edge.

Source files
------------

// File: rtl/alarm_mode_ctrl.sv
// alarm_mode_ctrl
// User-interface sequencer for the alarm clock. It decodes single-cycle
// button pulses (centre/up/down/left/right) and the 1 Hz tick. It then
// sequences the normal, adjust and ringing modes, issues inc/dec pulses to the
// external time counter, and holds the alarm time and alarm enable registers.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   btn_c/u/d/l/r     one-cycle button pulses
//   tick_1hz          one-cycle pulse per second
//   alarm_match       level, high while current time equals alarm time
//   adjust_mode       high in any adjust state
//   field_sel         0=time hr, 1=time min, 2=alarm hr, 3=alarm min (0 outside adjust)
//   field_blink       toggles on tick_1hz while adjusting
//   time_inc_hr, time_dec_hr, time_inc_min, time_dec_min
//                     one-cycle pulses to the time counter
//   alarm_hr          alarm hour, 0..HR_MAX
//   alarm_min         alarm minute, 0..MIN_MAX
//   alarm_en          alarm armed
//   ringing           high while the alarm rings
//
// Every output is a flop. A button pulse takes effect on the clock edge that
// follows the pulse cycle.
module alarm_mode_ctrl #(
  parameter int RING_SECS = 30,
  parameter int HR_MAX    = 23,
  parameter int MIN_MAX   = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_c,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       tick_1hz,
  input  logic       alarm_match,
  output logic       adjust_mode,
  output logic [1:0] field_sel,
  output logic       field_blink,
  output logic       time_inc_hr,
  output logic       time_dec_hr,
  output logic       time_inc_min,
  output logic       time_dec_min,
  output logic [4:0] alarm_hr,
  output logic [5:0] alarm_min,
  output logic       alarm_en,
  output logic       ringing
);

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    ADJ_T_HR  = 3'd1,
    ADJ_T_MIN = 3'd2,
    ADJ_A_HR  = 3'd3,
    ADJ_A_MIN = 3'd4,
    RINGING   = 3'd5
  } state_t;

  state_t     state, state_n;
  logic [7:0] ring_cnt, ring_cnt_n;
  logic       match_d;
  logic [4:0] alarm_hr_n;
  logic [5:0] alarm_min_n;
  logic       alarm_en_n;
  logic       field_blink_n;
  logic       time_inc_hr_n, time_dec_hr_n, time_inc_min_n, time_dec_min_n;

  logic       any_btn;
  logic       act_c, act_l, act_r, act_u, act_d;
  logic       match_rise;

  // Hour step with wrap: HR_MAX+1 -> 0 and 0-1 -> HR_MAX.
  function automatic logic [4:0] hr_step(input logic [4:0] v, input logic up);
    if (up) return (v >= 5'(HR_MAX)) ? 5'd0 : v + 5'd1;
    else    return (v == 5'd0) ? 5'(HR_MAX) : v - 5'd1;
  endfunction

  // Minute step with wrap: MIN_MAX+1 -> 0 and 0-1 -> MIN_MAX.
  function automatic logic [5:0] min_step(input logic [5:0] v, input logic up);
    if (up) return (v >= 6'(MIN_MAX)) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? 6'(MIN_MAX) : v - 6'd1;
  endfunction

  function automatic logic is_adj(input state_t s);
    return (s == ADJ_T_HR) || (s == ADJ_T_MIN) || (s == ADJ_A_HR) || (s == ADJ_A_MIN);
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      ADJ_T_MIN: return 2'd1;
      ADJ_A_HR:  return 2'd2;
      ADJ_A_MIN: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic state_t next_field(input state_t s);
    case (s)
      ADJ_T_HR:  return ADJ_T_MIN;
      ADJ_T_MIN: return ADJ_A_HR;
      ADJ_A_HR:  return ADJ_A_MIN;
      default:   return ADJ_T_HR;
    endcase
  endfunction

  function automatic state_t prev_field(input state_t s);
    case (s)
      ADJ_T_HR:  return ADJ_A_MIN;
      ADJ_T_MIN: return ADJ_T_HR;
      ADJ_A_HR:  return ADJ_T_MIN;
      default:   return ADJ_A_HR;
    endcase
  endfunction

  // Button priority: centre beats left/right, which beats up/down. Any
  // left/right activity (including l+r together) suppresses up/down, and
  // conflicting pairs cancel.
  assign any_btn    = btn_c | btn_u | btn_d | btn_l | btn_r;
  assign act_c      = btn_c;
  assign act_l      = !btn_c && btn_l && !btn_r;
  assign act_r      = !btn_c && btn_r && !btn_l;
  assign act_u      = !btn_c && !(btn_l || btn_r) && btn_u && !btn_d;
  assign act_d      = !btn_c && !(btn_l || btn_r) && btn_d && !btn_u;
  assign match_rise = alarm_match && !match_d;

  always_comb begin
    state_n        = state;
    ring_cnt_n     = ring_cnt;
    alarm_hr_n     = alarm_hr;
    alarm_min_n    = alarm_min;
    alarm_en_n     = alarm_en;
    time_inc_hr_n  = 1'b0;
    time_dec_hr_n  = 1'b0;
    time_inc_min_n = 1'b0;
    time_dec_min_n = 1'b0;

    case (state)
      CLOCK: begin
        if (match_rise && alarm_en) begin
          state_n    = RINGING;
          ring_cnt_n = 8'd0;
        end else if (act_c) begin
          state_n = ADJ_T_HR;
        end else if (act_u) begin
          alarm_en_n = 1'b1;
        end else if (act_d) begin
          alarm_en_n = 1'b0;
        end
      end

      ADJ_T_HR, ADJ_T_MIN, ADJ_A_HR, ADJ_A_MIN: begin
        if (act_c) begin
          state_n = CLOCK;
        end else if (act_r) begin
          state_n = next_field(state);
        end else if (act_l) begin
          state_n = prev_field(state);
        end else if (act_u || act_d) begin
          case (state)
            ADJ_T_HR: begin
              time_inc_hr_n = act_u;
              time_dec_hr_n = act_d;
            end
            ADJ_T_MIN: begin
              time_inc_min_n = act_u;
              time_dec_min_n = act_d;
            end
            ADJ_A_HR:  alarm_hr_n  = hr_step(alarm_hr, act_u);
            default:   alarm_min_n = min_step(alarm_min, act_u);
          endcase
        end
      end

      RINGING: begin
        // A button and the final tick in the same cycle both lead to CLOCK.
        if (any_btn) begin
          state_n = CLOCK;
        end else if (tick_1hz) begin
          ring_cnt_n = ring_cnt + 8'd1;
          if (ring_cnt + 8'd1 >= 8'(RING_SECS)) state_n = CLOCK;
        end
      end

      default: state_n = CLOCK;
    endcase

    // Blink phase restarts on any state change, so entering, leaving or
    // moving between fields always starts with the field shown.
    field_blink_n = (is_adj(state) && (state_n == state)) ? (field_blink ^ tick_1hz) : 1'b0;
  end

  // Register stage: state, alarm registers and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLOCK;
      ring_cnt     <= 8'd0;
      match_d      <= 1'b0;
      alarm_hr     <= 5'd0;
      alarm_min    <= 6'd0;
      alarm_en     <= 1'b0;
      field_blink  <= 1'b0;
      time_inc_hr  <= 1'b0;
      time_dec_hr  <= 1'b0;
      time_inc_min <= 1'b0;
      time_dec_min <= 1'b0;
      adjust_mode  <= 1'b0;
      field_sel    <= 2'd0;
      ringing      <= 1'b0;
    end else begin
      state        <= state_n;
      ring_cnt     <= ring_cnt_n;
      match_d      <= alarm_match;
      alarm_hr     <= alarm_hr_n;
      alarm_min    <= alarm_min_n;
      alarm_en     <= alarm_en_n;
      field_blink  <= field_blink_n;
      time_inc_hr  <= time_inc_hr_n;
      time_dec_hr  <= time_dec_hr_n;
      time_inc_min <= time_inc_min_n;
      time_dec_min <= time_dec_min_n;
      adjust_mode  <= is_adj(state_n);
      field_sel    <= sel_of(state_n);
      ringing      <= (state_n == RINGING);
    end
  end

endmodule
